cmd_sequencer: RTL and testbench
================================

// Module: cmd_sequencer
// PURPOSE
//  Command-stream source that sits directly upstream of RemoteComm in the Knight's Tour bench/system.
//  Buffers 16-bit Knight commands (cal 0x2xxx, move 0x4xxx, tour 0x6xxx), issues them one at a time,
//  and waits for each command's positive ack (0xA5) before issuing the next. Handshake failures are
//  reported: a non-ack response or a timeout halts the stream and sets a sticky error.
// PARAMETERS
//  DEPTH      8          command FIFO entries; power of 2, >=2
//  ACK_TMO    5_000_000  max clk cycles from cmd_sent to resp_rdy (moves/cal are slow)
//  SENT_TMO   100_000    max clk cycles from send_cmd pulse to cmd_sent
//  ACK_VAL    8'hA5      response value treated as positive acknowledge
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  push       in   1   write push_cmd into FIFO this cycle
//  push_cmd   in   16  command word to enqueue
//  full       out  1   FIFO holds DEPTH entries
//  empty      out  1   FIFO holds 0 entries
//  start      in   1   1-cycle pulse: begin draining FIFO (ignored unless IDLE)
//  clr_err    in   1   clears err/err_code, returns ERROR->IDLE; FIFO contents kept
//  cmd        out  16  command presented to RemoteComm
//  send_cmd   out  1   1-cycle pulse to RemoteComm
//  cmd_sent   in   1   RemoteComm finished transmitting cmd
//  resp_rdy   in   1   RemoteComm received a response byte (1-cycle pulse)
//  resp       in   8   response byte, valid when resp_rdy
//  busy       out  1   state not IDLE and not ERROR
//  done_cnt   out  8   commands acked since reset; wraps 255->0
//  err        out  1   sticky error
//  err_code   out  2   00 none, 01 bad resp, 10 ack timeout, 11 sent timeout
// BEHAVIOUR
//  Reset: FIFO empty (full=0, empty=1), state IDLE, cmd=16'h0000, send_cmd=0, busy=0,
//   done_cnt=0, err=0, err_code=00, timer=0. Reset mid-transfer aborts immediately; no pulse is emitted.
//  FIFO: push while full is dropped and FIFO is unchanged. Pop is internal (LOAD state).
//   Push and pop in the same cycle are both honoured, count unchanged; push on full+pop is accepted.
//   Pointers are log2(DEPTH) bits and wrap naturally.
//  FSM states IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, ERROR:
//   IDLE: start & !empty -> LOAD. start & empty -> stay IDLE.
//   LOAD: cmd <= FIFO head; pop; -> SEND (1 cycle).
//   SEND: send_cmd=1 for exactly this cycle; timer cleared; -> WAIT_SENT.
//   WAIT_SENT: cmd_sent -> WAIT_RESP, timer cleared; timer==SENT_TMO-1 -> ERROR, code 11.
//   WAIT_RESP: resp_rdy & resp==ACK_VAL -> done_cnt++, then LOAD if !empty else IDLE.
//     resp_rdy & resp!=ACK_VAL -> ERROR, code 01. timer==ACK_TMO-1 -> ERROR, code 10.
//     If resp_rdy and the timeout fall in the same cycle, resp_rdy wins.
//   ERROR: err=1, cmd holds last value; clr_err -> IDLE next cycle (err, err_code cleared).
//   A failed command is not retried or re-queued.
//  cmd is stable from LOAD until the next LOAD; it changes only in LOAD.
//  resp_rdy outside WAIT_RESP is ignored (no error). cmd_sent outside WAIT_SENT is ignored.
//  A command pushed during WAIT_RESP is issued back-to-back: LOAD follows the ack with no IDLE cycle.
//  Latency: start -> send_cmd pulse = 2 clk; ack -> next send_cmd = 2 clk.
//  Timer: 32-bit, saturates; counts only in WAIT_SENT/WAIT_RESP.
// TESTING
//  1 reset: assert rst mid-WAIT_RESP -> all outputs at reset values in same cycle, empty=1.
//  2 push 0x2000,0x4BF1,0x4002; start; model acks A5 -> 3 send_cmd pulses in order, done_cnt=3, IDLE.
//  3 push 8 with DEPTH=8 -> full=1; 9th push 0xDEAD dropped; drain -> 8 cmds, no 0xDEAD.
//  4 resp=0x5A to 0x4BF1 -> err=1, code 01, 2nd cmd not sent; clr_err+start -> resumes with next cmd.
//  5 ACK_TMO=100, no resp_rdy -> ERROR code 10 exactly 100 clks after cmd_sent; SENT_TMO case gives 11.
//  6 resp_rdy coincident with timeout cycle (resp 0xA5) -> ack taken, err=0; push during WAIT_RESP -> back-to-back.

Source files
------------

// File: rtl/cmd_sequencer_if.sv
// Command/response bundle between the sequencer, its command source and RemoteComm.
// The slave modport is the sequencer's view; master is whoever drives the commands and responses.
interface cmd_sequencer_if;
  logic        push;
  logic [15:0] push_cmd;
  logic        full;
  logic        empty;
  logic        start;
  logic        clr_err;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic [7:0]  done_cnt;
  logic        err;
  logic [1:0]  err_code;

  // Handshake: send_cmd is a one-cycle request with cmd stable; cmd_sent completes transmission,
  // resp_rdy is a one-cycle strobe qualifying resp; each is honoured only in its own wait state.
  modport master (
    output push, push_cmd, start, clr_err, cmd_sent, resp_rdy, resp,
    input  full, empty, cmd, send_cmd, busy, done_cnt, err, err_code
  );

  modport slave (
    input  push, push_cmd, start, clr_err, cmd_sent, resp_rdy, resp,
    output full, empty, cmd, send_cmd, busy, done_cnt, err, err_code
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Buffers Knight commands in a FIFO and issues them one at a time to RemoteComm,
// waiting for a positive ack per command; a bad response or timeout halts with a sticky error.
module cmd_sequencer #(
  parameter int         DEPTH    = 8,
  parameter int         ACK_TMO  = 5_000_000,
  parameter int         SENT_TMO = 100_000,
  parameter logic [7:0] ACK_VAL  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  cmd_sequencer_if.slave   io_bus,
  output logic [2:0]       o_state
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_SEND      = 3'd2;
  localparam logic [2:0] S_WAIT_SENT = 3'd3;
  localparam logic [2:0] S_WAIT_RESP = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [2:0]    r_state;
  logic [15:0]   r_cmd;
  logic [7:0]    r_done_cnt;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [31:0]   r_timer;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_ok;
  logic [2:0]    w_next;
  logic          w_ack;
  logic [1:0]    w_code;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = (r_state == S_LOAD);
  // A pop in the same cycle frees a slot, so a push on full is still taken then.
  assign w_push_ok = io_bus.push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= io_bus.push_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    w_code = 2'b00;
    case (r_state)
      S_IDLE:      if (io_bus.start && !w_empty) w_next = S_LOAD;
      S_LOAD:      w_next = S_SEND;
      S_SEND:      w_next = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (io_bus.cmd_sent) begin
          w_next = S_WAIT_RESP;
        end else if (r_timer == 32'(SENT_TMO - 1)) begin
          w_next = S_ERROR;
          w_code = 2'b11;
        end
      end
      S_WAIT_RESP: begin
        // A response arriving on the timeout cycle still counts.
        if (io_bus.resp_rdy) begin
          if (io_bus.resp == ACK_VAL) begin
            w_ack  = 1'b1;
            w_next = w_empty ? S_IDLE : S_LOAD;
          end else begin
            w_next = S_ERROR;
            w_code = 2'b01;
          end
        end else if (r_timer == 32'(ACK_TMO - 1)) begin
          w_next = S_ERROR;
          w_code = 2'b10;
        end
      end
      S_ERROR:     if (io_bus.clr_err) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= 16'h0000;
      r_done_cnt <= 8'd0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_timer    <= 32'd0;
    end else begin
      r_state <= w_next;

      if (r_state == S_LOAD) r_cmd <= r_mem[r_rd_ptr];
      if (w_ack)             r_done_cnt <= r_done_cnt + 8'd1;

      if (w_next == S_ERROR && r_state != S_ERROR) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end else if (r_state == S_ERROR && io_bus.clr_err) begin
        r_err      <= 1'b0;
        r_err_code <= 2'b00;
      end

      if (r_state == S_SEND || (r_state == S_WAIT_SENT && io_bus.cmd_sent)) begin
        r_timer <= 32'd0;
      end else if ((r_state == S_WAIT_SENT || r_state == S_WAIT_RESP) && r_timer != '1) begin
        r_timer <= r_timer + 32'd1;
      end
    end
  end

  assign io_bus.full     = w_full;
  assign io_bus.empty    = w_empty;
  assign io_bus.cmd      = r_cmd;
  assign io_bus.send_cmd = (r_state == S_SEND);
  assign io_bus.busy     = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign io_bus.done_cnt = r_done_cnt;
  assign io_bus.err      = r_err;
  assign io_bus.err_code = r_err_code;
  assign o_state         = r_state;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: scoreboard queue of issued commands, a RemoteComm-like responder,
// and checks of reset, ordering, FIFO full/drop, bad response, both timeouts and back-to-back issue.
module tb_cmd_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ERROR = 3'd5;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_done;
  int          total;
  int          bad;
  int          n_send;
  int          lat;
  int          snap;

  cmd_sequencer_if bus();

  cmd_sequencer #(
    .DEPTH(8),
    .ACK_TMO(100),
    .SENT_TMO(50),
    .ACK_VAL(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus),
    .o_state(state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(posedge clk) begin
    if (bus.send_cmd === 1'b1) n_send <= n_send + 1;
  end

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: each starts at a falling edge and ends at a falling edge
  task automatic push_t(input logic [15:0] c, input bit accept);
    bus.push     = 1'b1;
    bus.push_cmd = c;
    if (accept) exp_q.push_back(c);
    @(negedge clk);
    bus.push     = 1'b0;
  endtask

  task automatic start_t();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic clr_t();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic resp_t(input logic [7:0] b);
    bus.resp_rdy = 1'b1;
    bus.resp     = b;
    @(negedge clk);
    bus.resp_rdy = 1'b0;
  endtask

  task automatic sent_t();
    @(negedge clk);
    bus.cmd_sent = 1'b1;
    @(negedge clk);
    bus.cmd_sent = 1'b0;
  endtask

  // Waits for the send_cmd pulse, checks latency (2 clk after start/ack) and the command order.
  task automatic wait_send(input string tag);
    logic [15:0] exp_c;
    lat = 0;
    while (bus.send_cmd !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_seen"}, 32'(bus.send_cmd), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, "_cmd"}, 32'(bus.cmd), 32'(exp_c));
  endtask

  task automatic serve_ack(input string tag);
    wait_send(tag);
    sent_t();
    repeat ($urandom_range(0, 6)) @(negedge clk);
    resp_t(8'hA5);
    exp_done = exp_done + 8'd1;
    chk({tag, "_done"}, 32'(bus.done_cnt), 32'(exp_done));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd"},   32'(bus.cmd),      32'h0);
    chk({tag, "_send"},  32'(bus.send_cmd), 32'h0);
    chk({tag, "_busy"},  32'(bus.busy),     32'h0);
    chk({tag, "_empty"}, 32'(bus.empty),    32'h1);
    chk({tag, "_full"},  32'(bus.full),     32'h0);
    chk({tag, "_done"},  32'(bus.done_cnt), 32'h0);
    chk({tag, "_err"},   32'(bus.err),      32'h0);
    chk({tag, "_code"},  32'(bus.err_code), 32'h0);
    chk({tag, "_state"}, 32'(state),        32'(ST_IDLE));
  endtask

  initial begin
    total = 0; bad = 0; n_send = 0; exp_done = 8'd0;
    rst = 1'b1;
    bus.push = 1'b0; bus.push_cmd = 16'h0; bus.start = 1'b0; bus.clr_err = 1'b0;
    bus.cmd_sent = 1'b0; bus.resp_rdy = 1'b0; bus.resp = 8'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // three commands acked in order
    push_t(16'h2000, 1'b1);
    push_t(16'h4BF1, 1'b1);
    push_t(16'h4002, 1'b1);
    chk("t2_empty_before", 32'(bus.empty), 32'h0);
    start_t();
    serve_ack("t2_c0");
    serve_ack("t2_c1");
    serve_ack("t2_c2");
    chk("t2_done3", 32'(bus.done_cnt), 32'd3);
    chk("t2_idle", 32'(state), 32'(ST_IDLE));
    chk("t2_sends", 32'(n_send), 32'd3);

    // reset asserted while waiting for a response takes effect at once
    push_t(16'h2ABC, 1'b1);
    start_t();
    wait_send("t1");
    sent_t();
    chk("t1_busy_pre", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t1_rst");
    exp_done = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // fill to DEPTH, drop a ninth push, drain eight
    for (int i = 0; i < 8; i++) begin
      push_t(16'h4100 + 16'(i * 3), 1'b1);
      chk("t3_full_fill", 32'(bus.full), (i == 7) ? 32'h1 : 32'h0);
    end
    push_t(16'hDEAD, 1'b0);
    chk("t3_full_after_drop", 32'(bus.full), 32'h1);
    start_t();
    for (int i = 0; i < 8; i++) serve_ack("t3_drain");
    chk("t3_empty", 32'(bus.empty), 32'h1);
    chk("t3_idle", 32'(state), 32'(ST_IDLE));
    chk("t3_done8", 32'(bus.done_cnt), 32'd8);

    // bad response halts the stream; clear and restart picks up the next command
    push_t(16'h2000, 1'b1);
    push_t(16'h4BF1, 1'b1);
    push_t(16'h4002, 1'b1);
    start_t();
    serve_ack("t4_c0");
    wait_send("t4_c1");
    sent_t();
    resp_t(8'h5A);
    chk("t4_err", 32'(bus.err), 32'h1);
    chk("t4_code", 32'(bus.err_code), 32'h1);
    chk("t4_state", 32'(state), 32'(ST_ERROR));
    snap = n_send;
    repeat (10) @(negedge clk);
    chk("t4_no_send", 32'(n_send), 32'(snap));
    chk("t4_cmd_hold", 32'(bus.cmd), 32'h4BF1);
    chk("t4_busy", 32'(bus.busy), 32'h0);
    clr_t();
    chk("t4_clr_err", 32'(bus.err), 32'h0);
    chk("t4_clr_code", 32'(bus.err_code), 32'h0);
    chk("t4_clr_idle", 32'(state), 32'(ST_IDLE));
    chk("t4_fifo_kept", 32'(bus.empty), 32'h0);
    start_t();
    serve_ack("t4_resume");

    // ack timeout lands exactly 100 clocks after cmd_sent
    push_t(16'h4123, 1'b1);
    start_t();
    wait_send("t5a");
    sent_t();
    repeat (99) @(negedge clk);
    chk("t5a_err_early", 32'(bus.err), 32'h0);
    @(negedge clk);
    chk("t5a_err", 32'(bus.err), 32'h1);
    chk("t5a_code", 32'(bus.err_code), 32'h2);
    clr_t();

    // no cmd_sent: sent timeout 50 clocks after leaving SEND
    push_t(16'h6000, 1'b1);
    start_t();
    wait_send("t5b");
    repeat (50) @(negedge clk);
    chk("t5b_err_early", 32'(bus.err), 32'h0);
    @(negedge clk);
    chk("t5b_err", 32'(bus.err), 32'h1);
    chk("t5b_code", 32'(bus.err_code), 32'h3);
    clr_t();

    // strobes outside their wait states are ignored
    resp_t(8'h5A);
    bus.cmd_sent = 1'b1;
    @(negedge clk);
    bus.cmd_sent = 1'b0;
    chk("t6_stray_err", 32'(bus.err), 32'h0);
    chk("t6_stray_idle", 32'(state), 32'(ST_IDLE));

    // ack on the timeout cycle wins; a push during WAIT_RESP issues back-to-back
    push_t(16'h6001, 1'b1);
    start_t();
    wait_send("t6_c0");
    sent_t();
    push_t(16'h6002, 1'b1);
    repeat (98) @(negedge clk);
    resp_t(8'hA5);
    exp_done = exp_done + 8'd1;
    chk("t6_edge_err", 32'(bus.err), 32'h0);
    chk("t6_edge_done", 32'(bus.done_cnt), 32'(exp_done));
    chk("t6_b2b_load", 32'(state), 32'(ST_LOAD));
    serve_ack("t6_c1");
    chk("t6_idle", 32'(state), 32'(ST_IDLE));
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
